// File: rtl/hazard_ctrl_if.sv
// Hazard-control bundle between the pipelined controller/datapath (master)
// and hazard_ctrl (slave): decode/execute hazard inputs and stall/flush/forward outputs.
interface hazard_ctrl_if;
  logic [3:0] RA1D;
  logic [3:0] RA2D;
  logic [3:0] WA3D;
  logic       RegWriteD;
  logic       MemtoRegD;
  logic       PCSrcD;
  logic       RegWriteEOut;
  logic       PCSrcEOut;
  logic       BranchTakenE;
  logic [1:0] ForwardAE;
  logic [1:0] ForwardBE;
  logic       StallF;
  logic       StallD;
  logic       FlushD;
  logic       FlushE;

  modport master (
    output RA1D, RA2D, WA3D, RegWriteD, MemtoRegD, PCSrcD,
    output RegWriteEOut, PCSrcEOut, BranchTakenE,
    input  ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE
  );

  modport slave (
    input  RA1D, RA2D, WA3D, RegWriteD, MemtoRegD, PCSrcD,
    input  RegWriteEOut, PCSrcEOut, BranchTakenE,
    output ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage ARM pipeline: shadow E/M/W register tracking,
// forwarding selects, load-use stall, branch and PC-write flushes. HAZARD_PERF_EN adds counters.
module hazard_ctrl (
  input  logic          clk,
  input  logic          reset,
  hazard_ctrl_if.slave  hz
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]   StallCount,
  output logic [31:0]   FlushCount
`endif
);

  logic       validD;
  logic [3:0] RA1E, RA2E, WA3E;
  logic       RegWriteE, MemtoRegE, PCSrcE;
  logic [3:0] WA3M, WA3W;
  logic       RegWriteM, PCSrcM, RegWriteW, PCSrcW;

  logic       regWriteDq, memtoRegDq, pcSrcDq;
  logic       ldrStall, pcWrPending;
  logic [1:0] forwardA, forwardB;
  logic       stallF, stallD, flushD, flushE;

  // M beats W; R15 is never forwarded because it is read from the PC path
  function automatic logic [1:0] fwdSel(
    input logic [3:0] ra,
    input logic       regWriteM, input logic [3:0] wa3M,
    input logic       regWriteW, input logic [3:0] wa3W
  );
    logic [1:0] sel;
    if (regWriteM && (wa3M == ra) && (ra != 4'd15)) begin
      sel = 2'b10;
    end else if (regWriteW && (wa3W == ra) && (ra != 4'd15)) begin
      sel = 2'b01;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  // Hazard detection and stall/flush/forward decode
  always_comb begin
    regWriteDq  = hz.RegWriteD & validD;
    memtoRegDq  = hz.MemtoRegD & validD;
    pcSrcDq     = hz.PCSrcD & validD;
    ldrStall    = MemtoRegE & RegWriteE & validD &
                  ((WA3E == hz.RA1D) | (WA3E == hz.RA2D));
    pcWrPending = pcSrcDq | PCSrcE | PCSrcM;
    forwardA    = fwdSel(RA1E, RegWriteM, WA3M, RegWriteW, WA3W);
    forwardB    = fwdSel(RA2E, RegWriteM, WA3M, RegWriteW, WA3W);
    stallF      = ldrStall | pcWrPending;
    stallD      = ldrStall;
    flushD      = pcWrPending | PCSrcW | hz.BranchTakenE;
    flushE      = ldrStall | hz.BranchTakenE;
  end

  assign hz.ForwardAE = forwardA;
  assign hz.ForwardBE = forwardB;
  assign hz.StallF    = stallF;
  assign hz.StallD    = stallD;
  assign hz.FlushD    = flushD;
  assign hz.FlushE    = flushE;

  // Shadow pipeline of register numbers and write flags
  always_ff @(posedge clk) begin
    if (!reset) begin
      validD    <= 1'b0;
      RA1E      <= 4'd0;
      RA2E      <= 4'd0;
      WA3E      <= 4'd0;
      RegWriteE <= 1'b0;
      MemtoRegE <= 1'b0;
      PCSrcE    <= 1'b0;
      WA3M      <= 4'd0;
      RegWriteM <= 1'b0;
      PCSrcM    <= 1'b0;
      WA3W      <= 4'd0;
      RegWriteW <= 1'b0;
      PCSrcW    <= 1'b0;
    end else begin
      // validD drops after a flush only once decode is free to advance
      if (stallD) begin
        validD <= validD;
      end else begin
        validD <= !flushD;
      end
      if (flushE) begin
        RA1E      <= 4'd0;
        RA2E      <= 4'd0;
        WA3E      <= 4'd0;
        RegWriteE <= 1'b0;
        MemtoRegE <= 1'b0;
        PCSrcE    <= 1'b0;
      end else begin
        RA1E      <= hz.RA1D;
        RA2E      <= hz.RA2D;
        WA3E      <= hz.WA3D;
        RegWriteE <= regWriteDq;
        MemtoRegE <= memtoRegDq;
        PCSrcE    <= pcSrcDq;
      end
      WA3M      <= WA3E;
      RegWriteM <= hz.RegWriteEOut;
      PCSrcM    <= hz.PCSrcEOut;
      WA3W      <= WA3M;
      RegWriteW <= RegWriteM;
      PCSrcW    <= PCSrcM;
    end
  end

`ifdef HAZARD_PERF_EN
  // Load-use stall and taken-branch event counters, wrapping at 2^32
  always_ff @(posedge clk) begin
    if (!reset) begin
      StallCount <= 32'd0;
      FlushCount <= 32'd0;
    end else begin
      if (ldrStall) begin
        StallCount <= StallCount + 32'd1;
      end else begin
        StallCount <= StallCount;
      end
      if (hz.BranchTakenE) begin
        FlushCount <= FlushCount + 32'd1;
      end else begin
        FlushCount <= FlushCount;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: each cycle's expected outputs are queued when the
// stimulus is driven and compared on the following falling edge.
module tb_hazard_ctrl;
  logic clk;
  logic rstn;

  hazard_ctrl_if hz ();

`ifdef HAZARD_PERF_EN
  logic [31:0] stallCount;
  logic [31:0] flushCount;
`endif

  hazard_ctrl dut (
    .clk   (clk),
    .reset (rstn),
    .hz    (hz.slave)
`ifdef HAZARD_PERF_EN
    ,
    .StallCount (stallCount),
    .FlushCount (flushCount)
`endif
  );

  typedef struct {
    string      tag;
    logic [7:0] expv;
  } exp_t;

  exp_t expQ[$];
  exp_t cur;
  int   nChecks = 0;
  int   nPass   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] want);
    nChecks++;
    if (obs === want) begin
      nPass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h", tag, obs, want);
    end
  endtask

  // ctrl = {RegWriteD, MemtoRegD, PCSrcD, RegWriteEOut, PCSrcEOut, BranchTakenE}
  // expv = {ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE}
  task automatic step(input string tag, input logic [3:0] ra1, input logic [3:0] ra2,
                      input logic [3:0] wa3, input logic [5:0] ctrl, input logic [7:0] expv);
    exp_t e;
    @(posedge clk);
    #1;
    hz.RA1D         = ra1;
    hz.RA2D         = ra2;
    hz.WA3D         = wa3;
    hz.RegWriteD    = ctrl[5];
    hz.MemtoRegD    = ctrl[4];
    hz.PCSrcD       = ctrl[3];
    hz.RegWriteEOut = ctrl[2];
    hz.PCSrcEOut    = ctrl[1];
    hz.BranchTakenE = ctrl[0];
    e.tag  = tag;
    e.expv = expv;
    expQ.push_back(e);
  endtask

  always @(negedge clk) begin
    if (expQ.size() != 0) begin
      cur = expQ.pop_front();
      checkEq({cur.tag, ".ForwardAE"}, {30'd0, hz.ForwardAE}, {30'd0, cur.expv[7:6]});
      checkEq({cur.tag, ".ForwardBE"}, {30'd0, hz.ForwardBE}, {30'd0, cur.expv[5:4]});
      checkEq({cur.tag, ".StallF"},    {31'd0, hz.StallF},    {31'd0, cur.expv[3]});
      checkEq({cur.tag, ".StallD"},    {31'd0, hz.StallD},    {31'd0, cur.expv[2]});
      checkEq({cur.tag, ".FlushD"},    {31'd0, hz.FlushD},    {31'd0, cur.expv[1]});
      checkEq({cur.tag, ".FlushE"},    {31'd0, hz.FlushE},    {31'd0, cur.expv[0]});
    end
  end

  initial begin
    rstn            = 1'b0;
    hz.RA1D         = 4'd0;
    hz.RA2D         = 4'd0;
    hz.WA3D         = 4'd0;
    hz.RegWriteD    = 1'b0;
    hz.MemtoRegD    = 1'b0;
    hz.PCSrcD       = 1'b0;
    hz.RegWriteEOut = 1'b0;
    hz.PCSrcEOut    = 1'b0;
    hz.BranchTakenE = 1'b0;

    step("rst0", 4'd0, 4'd0, 4'd0, 6'b000000, 8'b00_00_0000);
    rstn = 1'b1;
    step("idle", 4'd0, 4'd0, 4'd0, 6'b000000, 8'b00_00_0000);

    // ADD R1 then two readers of R1: forward from M, then from W
    step("alu1", 4'd4,  4'd5, 4'd1, 6'b100000, 8'b00_00_0000);
    step("alu2", 4'd1,  4'd6, 4'd7, 6'b100100, 8'b00_00_0000);
    step("alu3", 4'd1,  4'd0, 4'd0, 6'b000100, 8'b10_00_0000);
    step("alu4", 4'd0,  4'd0, 4'd0, 6'b000000, 8'b01_00_0000);
    step("alu5", 4'd0,  4'd0, 4'd0, 6'b000000, 8'b00_00_0000);
    step("alu6", 4'd0,  4'd0, 4'd0, 6'b000000, 8'b00_00_0000);

    // LDR R2 then ADD reading R2 as SrcB
    step("ld1",  4'd8,  4'd9, 4'd2,  6'b110000, 8'b00_00_0000);
    step("ld2",  4'd10, 4'd2, 4'd11, 6'b100100, 8'b00_00_1101);
    step("ld3",  4'd10, 4'd2, 4'd11, 6'b100000, 8'b00_00_0000);
`ifdef HAZARD_PERF_EN
    checkEq("perf.stall1", stallCount, 32'd1);
    checkEq("perf.flush0", flushCount, 32'd0);
`endif
    step("ld4",  4'd0,  4'd0, 4'd0,  6'b000100, 8'b00_01_0000);
    step("ld5",  4'd0,  4'd0, 4'd0,  6'b000000, 8'b00_00_0000);
    step("ld6",  4'd0,  4'd0, 4'd0,  6'b000000, 8'b00_00_0000);

    // condition-failed write to R3 must not be forwarded from M or W
    step("cf1",  4'd12, 4'd13, 4'd3, 6'b100000, 8'b00_00_0000);
    step("cf2",  4'd3,  4'd14, 4'd0, 6'b000000, 8'b00_00_0000);
    step("cf3",  4'd3,  4'd0,  4'd0, 6'b000000, 8'b00_00_0000);
    step("cf4",  4'd0,  4'd0,  4'd0, 6'b000000, 8'b00_00_0000);
    step("cf5",  4'd0,  4'd0,  4'd0, 6'b000000, 8'b00_00_0000);

    // writer of R15 followed by R15 readers: never forwarded
    step("r15a", 4'd0,  4'd0,  4'd15, 6'b100000, 8'b00_00_0000);
    step("r15b", 4'd15, 4'd15, 4'd0,  6'b000100, 8'b00_00_0000);
    step("r15c", 4'd15, 4'd0,  4'd0,  6'b000000, 8'b00_00_0000);
    step("r15d", 4'd0,  4'd0,  4'd0,  6'b000000, 8'b00_00_0000);
    step("r15e", 4'd0,  4'd0,  4'd0,  6'b000000, 8'b00_00_0000);
    step("r15f", 4'd0,  4'd0,  4'd0,  6'b000000, 8'b00_00_0000);

    // PC write decoded at t: StallF t..t+2, FlushD t..t+3; invalid D slot ignored at t+4
    step("pc_t0", 4'd1, 4'd2, 4'd15, 6'b001000, 8'b00_00_1010);
    step("pc_t1", 4'd0, 4'd0, 4'd0,  6'b000010, 8'b00_00_1010);
    step("pc_t2", 4'd0, 4'd0, 4'd0,  6'b000000, 8'b00_00_1010);
    step("pc_t3", 4'd0, 4'd0, 4'd0,  6'b000000, 8'b00_00_0010);
    step("pc_t4", 4'd0, 4'd0, 4'd6,  6'b111000, 8'b00_00_0000);
    step("pc_t5", 4'd6, 4'd0, 4'd0,  6'b000000, 8'b00_00_0000);

    // load-use stall coinciding with a taken branch: branch wins, no repeat stall
    step("br1",  4'd0, 4'd0, 4'd4, 6'b110000, 8'b00_00_0000);
    step("br2",  4'd4, 4'd0, 4'd7, 6'b100001, 8'b00_00_1111);
    step("br3",  4'd0, 4'd0, 4'd0, 6'b000000, 8'b00_00_0000);
`ifdef HAZARD_PERF_EN
    checkEq("perf.stall2", stallCount, 32'd2);
    checkEq("perf.flush1", flushCount, 32'd1);
`endif

    // reset in the middle of a PC-write sequence
    step("rs1",  4'd0, 4'd0, 4'd0, 6'b001000, 8'b00_00_1010);
    step("rs2",  4'd0, 4'd0, 4'd0, 6'b000010, 8'b00_00_1010);
    rstn = 1'b0;
    step("rs3",  4'd0, 4'd0, 4'd0, 6'b000000, 8'b00_00_0000);
    rstn = 1'b1;
`ifdef HAZARD_PERF_EN
    checkEq("perf.stallRst", stallCount, 32'd0);
    checkEq("perf.flushRst", flushCount, 32'd0);
`endif
    step("rs4",  4'd0, 4'd0, 4'd0, 6'b000000, 8'b00_00_0000);
    step("rs5",  4'd0, 4'd0, 4'd0, 6'b000000, 8'b00_00_0000);

    @(negedge clk);
    #1;
    checkEq("queueDrained", expQ.size(), 32'd0);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

- Pipeline hazard controller for the 5-stage ARM core; sits beside the pipelined controller and the datapath.
- Keeps its own shadow pipeline of destination and source register numbers and write/PC-write flags across E, M and W.
- From these it drives the forwarding selects, the load-use stall, the branch flushes and the PC-write flushes that the controller's flush inputs and the datapath's stall/flush enables consume.

## Interface
Parameters:
- none (register index width fixed at 4, R15 = PC)

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-low reset (0 = reset, sampled on rising clk)
- RA1D  in  4  decode-stage source register 1
- RA2D  in  4  decode-stage source register 2
- WA3D  in  4  decode-stage destination register
- RegWriteD  in  1  decode-stage register write (unconditioned)
- MemtoRegD  in  1  decode-stage load
- PCSrcD  in  1  decode-stage write to R15
- RegWriteEOut  in  1  execute-stage register write after condition check
- PCSrcEOut  in  1  execute-stage PC write after condition check
- BranchTakenE  in  1  branch resolved taken in execute
- ForwardAE  out  2  SrcA select: 00 register file, 01 ResultW, 10 ALUResultM
- ForwardBE  out  2  SrcB select, same encoding
- StallF  out  1  hold fetch PC
- StallD  out  1  hold decode register
- FlushD  out  1  clear decode register
- FlushE  out  1  clear execute register (feeds controller FlushE)

## Operation
Shadow state, all registered:
- validD.
- E stage: RA1E, RA2E, WA3E, RegWriteE, MemtoRegE, PCSrcE.
- M stage: WA3M, RegWriteM, PCSrcM.
- W stage: WA3W, RegWriteW, PCSrcW.

Decode qualification:
- Effective D flags are RegWriteD/MemtoRegD/PCSrcD ANDed with validD.
- When validD = 0, RA1D/RA2D take part in no hazard compare.

D→E update (every edge):
- If FlushE: all E fields load 0.
- Otherwise they load the qualified D values.

E→M update:
- WA3M ← WA3E.
- RegWriteM ← RegWriteEOut; PCSrcM ← PCSrcEOut (condition-gated values).

M→W update:
- Straight copy.

validD update:
- If StallD: hold.
- Else: validD ← !FlushD.

Forwarding (per operand X ∈ {1,2}, combinational from E/M/W shadow state):
- 10 if RegWriteM && WA3M == RAXE && RAXE != 15.
- Else 01 if RegWriteW && WA3W == RAXE && RAXE != 15.
- Else 00.
- M has priority over W.

Hazard terms:
- LDRstall = MemtoRegE && RegWriteE && validD && (WA3E == RA1D || WA3E == RA2D).
- PCWrPending = PCSrcD(qualified) || PCSrcE || PCSrcM.

Outputs:
- StallF = LDRstall || PCWrPending.
- StallD = LDRstall.
- FlushD = PCWrPending || PCSrcW || BranchTakenE.
- FlushE = LDRstall || BranchTakenE.

Simultaneous events:
- LDRstall with BranchTakenE: FlushE = 1 and FlushD = 1. The branch wins; the stalled instruction is discarded on the next edge.
- StallD with FlushD: the flush clears the D register. validD holds, but becomes 0 on the following non-stalled edge because FlushD persists while the PC write is pending.

## Timing
- All outputs are combinational from registered shadow state plus current D/E inputs; no added latency.
- Load-use: exactly 1 stall cycle (StallF = StallD = FlushE = 1 for one cycle). The consumer then forwards via 01 from W.
- PC write by an instruction decoded in cycle t:
  - StallF asserted cycles t..t+2.
  - FlushD asserted cycles t..t+3.
  - Fetch resumes with the new PC at t+4.
- Taken branch resolved in E: FlushD and FlushE asserted that cycle only.

Reset (reset = 0 at a rising edge):
- All shadow registers clear; validD = 0.
- Outputs settle to ForwardAE = ForwardBE = 00, all stall/flush = 0 in the cycle after.
- Reset mid-stall or mid-flush abandons the sequence with no residual state.

## Configuration
- HAZARD_PERF_EN defined adds two outputs:
  - StallCount (32): cycles with LDRstall = 1.
  - FlushCount (32): cycles with BranchTakenE = 1.
  - Both clear on reset, increment by 1 per qualifying cycle, and wrap at 2^32−1 → 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

## Test plan
- ALU back-to-back: ADD R1 writes (RegWriteEOut = 1, WA3 = 1), next instruction reads RA1 = 1 → ForwardAE = 10 in its E cycle. One instruction later → 01 from W.
- Load-use: LDR R2 then ADD reading RA2D = 2 → one cycle of StallF = StallD = FlushE = 1, then ForwardBE = 01. With HAZARD_PERF_EN, StallCount = 1.
- Condition-failed write: RegWriteEOut = 0 for an instruction with WA3 = 3 → a subsequent reader of R3 gets ForwardAE = 00.
- R15 source: RegWriteM = 1, WA3M = 15, RA1E = 15 → ForwardAE = 00.
- PC write (PCSrcD = 1 at cycle t) → StallF = 1 for t..t+2, FlushD = 1 for t..t+3, and both are 0 at t+4.
- BranchTakenE = 1 in the same cycle as an LDRstall → FlushD = FlushE = 1, and no stall repeats next cycle. Assert reset = 0 mid-sequence → all outputs 0 the following cycle.
